// File: rtl/alux_pkg.sv
// Shared definitions for the complex-ALU arbiter: opcodes, data widths and FSM states.
package alux_pkg;

  localparam int DATA_W = 64;
  localparam int HALF_W = 32;

  localparam logic [3:0] OP_A     = 4'd0;
  localparam logic [3:0] OP_B     = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_MUL   = 4'd4;
  localparam logic [3:0] OP_MULRI = 4'd6;
  localparam logic [3:0] OP_EQ    = 4'd8;
  localparam logic [3:0] OP_MODA  = 4'd9;
  localparam logic [3:0] OP_MODB  = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE,
    ST_RESP
  } arb_state_e;

  function automatic logic [1:0] onehot2(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alux_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester that was not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant,
  output logic [1:0] grant_oh
);

  always_comb begin
    grant_valid = |req;
    grant       = 1'b0;
    grant_oh    = 2'b00;
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else begin
      grant = req[1];
    end
    if (grant_valid) begin
      grant_oh = grant ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alux_arbiter.sv
// Shares one complex ALU between two requesters, one operation in flight, with a watchdog.
// Define ALUX_ARB_STATS_EN to add the stat_ops / stat_tmo counter outputs.
module alux_arbiter
  import alux_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int NREQ    = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*4-1:0]      req_opr,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_err,
  output logic                   alu_start,
  output logic [3:0]             alu_opr,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  input  logic                   alu_done,
  input  logic [DATA_W-1:0]      alu_result
`ifdef ALUX_ARB_STATS_EN
  ,
  output logic [31:0]            stat_ops,
  output logic [7:0]             stat_tmo
`endif
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic             gnt_q;
  logic             rr_ptr_q;
  logic             last_grant;
  logic [CNT_W-1:0] cnt_q;
  logic             grant_valid, grant;
  logic [1:0]       grant_oh;
  logic             accept, done_hit, tmo_hit, rsp_take;

  // rr_ptr_q names the requester that wins the next tie, so the last winner is its complement
  assign last_grant = ~rr_ptr_q;

  rr_arbiter2 u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant_valid(grant_valid),
    .grant      (grant),
    .grant_oh   (grant_oh)
  );

  assign req_ready = (state_q == ST_IDLE && reset) ? grant_oh : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    done_hit = 1'b0;
    tmo_hit  = 1'b0;
    rsp_take = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          accept  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (alu_done) begin
          done_hit = 1'b1;
          state_d  = ST_CAPTURE;
        end else if (cnt_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready[gnt_q]) begin
          rsp_take = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A done in the last watchdog cycle still counts as a normal completion
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gnt_q     <= 1'b0;
      rr_ptr_q  <= 1'b0;
      cnt_q     <= '0;
      alu_start <= 1'b0;
      alu_opr   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        gnt_q   <= grant;
        alu_opr <= grant ? req_opr[7:4] : req_opr[3:0];
        alu_a   <= grant ? req_a[127:64] : req_a[63:0];
        alu_b   <= grant ? req_b[127:64] : req_b[63:0];
      end
      if (state_q == ST_ISSUE) begin
        alu_start <= 1'b1;
        cnt_q     <= '0;
      end
      if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (done_hit) begin
        alu_start <= 1'b0;
      end
      if (tmo_hit) begin
        alu_start <= 1'b0;
        rsp_data  <= '0;
        rsp_err   <= 1'b1;
        rsp_valid <= onehot2(gnt_q);
      end
      if (state_q == ST_CAPTURE) begin
        rsp_data  <= alu_result;
        rsp_err   <= 1'b0;
        rsp_valid <= onehot2(gnt_q);
      end
      if (rsp_take) begin
        rsp_valid <= '0;
        rr_ptr_q  <= ~gnt_q;
      end
    end
  end

`ifdef ALUX_ARB_STATS_EN
  logic [15:0] ops0_q, ops1_q;
  logic [7:0]  tmo_q;

  // Only error-free responses count as completed; all counters stick at their maximum
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ops0_q <= '0;
      ops1_q <= '0;
      tmo_q  <= '0;
    end else begin
      if (rsp_take && !rsp_err) begin
        if (!gnt_q && ops0_q != '1) ops0_q <= ops0_q + 1'b1;
        if (gnt_q && ops1_q != '1) ops1_q <= ops1_q + 1'b1;
      end
      if (tmo_hit && tmo_q != '1) begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

  assign stat_ops = {ops1_q, ops0_q};
  assign stat_tmo = tmo_q;
`endif

endmodule

// File: tb/tb_alux_arbiter.sv
// Bench for alux_arbiter: transaction/latency model, an ALU responder and directed scenarios.
module tb_alux_arbiter;
  import alux_pkg::*;

  localparam int TO = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0]   req_opr;
  logic [127:0] req_a, req_b;
  logic [63:0]  rsp_data, alu_a, alu_b;
  logic         rsp_err, alu_start;
  logic [3:0]   alu_opr;
  logic         alu_done = 1'b0;
  logic [63:0]  alu_result = 64'd0;
`ifdef ALUX_ARB_STATS_EN
  logic [31:0]  stat_ops;
  logic [7:0]   stat_tmo;
`endif

  always #5 clock = ~clock;

  alux_arbiter #(.TIMEOUT(TO), .NREQ(2)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_opr(req_opr),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_start(alu_start), .alu_opr(alu_opr), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result)
`ifdef ALUX_ARB_STATS_EN
    , .stat_ops(stat_ops), .stat_tmo(stat_tmo)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] alu_fn(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] ar, ai, br, bi;
    ar = a[63:32]; ai = a[31:0]; br = b[63:32]; bi = b[31:0];
    case (op)
      OP_A:    return a;
      OP_B:    return b;
      OP_ADD:  return {ar + br, ai + bi};
      OP_SUB:  return {ar - br, ai - bi};
      default: return 64'd0;
    endcase
  endfunction

  // ALU responder: done pulses alu_lat cycles after start first goes high
  int alu_lat = 2;
  int scnt = 0;
  always @(posedge clock) begin
    #1;
    if (alu_start) begin
      scnt = scnt + 1;
      if (scnt == 1) alu_result = 64'hBAD0_BAD0_BAD0_BAD0;
      alu_done = (scnt == alu_lat + 1);
      if (alu_done) alu_result = alu_fn(alu_opr, alu_a, alu_b);
    end else begin
      scnt = 0;
      alu_done = 1'b0;
    end
  end

  // Model: t counts cycles since the accepting cycle; start spans t=2..2+E, response follows
  logic        m_busy = 1'b0, m_g = 1'b0, m_prio = 1'b0, m_err = 1'b0;
  int          m_t = 0, m_e = 0, m_resp_t = 0;
  logic [63:0] m_data, m_a, m_b;
  logic [3:0]  m_opr;
  int          cyc = 0, acc_cyc = 0, last_lat = -1, start_cnt = 0, last_start_cnt = 0;
  int          m_ops0 = 0, m_ops1 = 0, m_tmo = 0;
  logic [65:0] rsp_log[$];

  always @(negedge clock) begin
    logic [1:0] exp_ready, exp_rv;
    logic       exp_start, g;
    cyc++;
    if (!reset) begin
      checkOutput("reset_ctrl", {req_ready, rsp_valid, rsp_err, alu_start, alu_opr}, '0);
      checkOutput("reset_rsp_data", rsp_data, '0);
      checkOutput("reset_alu_ops", {alu_a, alu_b}, '0);
      m_busy = 1'b0; m_prio = 1'b0;
      m_ops0 = 0; m_ops1 = 0; m_tmo = 0;
    end else begin
      exp_ready = 2'b00;
      g = 1'b0;
      if (!m_busy && req_valid != 2'b00) begin
        g = (req_valid == 2'b11) ? m_prio : req_valid[1];
        exp_ready = g ? 2'b10 : 2'b01;
      end
      checkOutput("req_ready", req_ready, exp_ready);
      exp_start = m_busy && m_t >= 2 && m_t <= 2 + m_e;
      checkOutput("alu_start", alu_start, exp_start);
      if (exp_start) begin
        checkOutput("alu_opr", alu_opr, m_opr);
        checkOutput("alu_operands", {alu_a, alu_b}, {m_a, m_b});
      end
      exp_rv = (m_busy && m_t >= m_resp_t) ? (m_g ? 2'b10 : 2'b01) : 2'b00;
      checkOutput("rsp_valid", rsp_valid, exp_rv);
      if (exp_rv != 2'b00) begin
        checkOutput("rsp_data", rsp_data, m_data);
        checkOutput("rsp_err", rsp_err, m_err);
      end
      if (m_busy && alu_start) start_cnt++;
      if (m_busy && rsp_valid != 2'b00 && last_lat < 0) last_lat = cyc - acc_cyc;
      if (!m_busy) begin
        if (req_valid != 2'b00) begin
          m_busy = 1'b1; m_t = 1; m_g = g;
          m_opr = req_opr[g*4 +: 4];
          m_a = req_a[g*64 +: 64];
          m_b = req_b[g*64 +: 64];
          m_err = (alu_lat > TO - 1);
          m_e = m_err ? TO - 1 : alu_lat;
          m_resp_t = m_err ? 3 + m_e : 4 + m_e;
          m_data = m_err ? 64'd0 : alu_fn(m_opr, m_a, m_b);
          acc_cyc = cyc; last_lat = -1; start_cnt = 0;
        end
      end else if (m_t >= m_resp_t && rsp_ready[m_g]) begin
        rsp_log.push_back({m_g, rsp_err, rsp_data});
        last_start_cnt = start_cnt;
        if (m_err) m_tmo++;
        else if (m_g) m_ops1++;
        else m_ops0++;
        m_busy = 1'b0;
        m_prio = ~m_g;
      end else begin
        m_t++;
      end
    end
  end

  task automatic tick();
    logic [1:0] took;
    @(negedge clock);
    took = req_valid & req_ready;
    @(posedge clock);
    #1;
    req_valid = req_valid & ~took;
  endtask

  task automatic applyStimulus(input int r, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    req_valid[r] = 1'b1;
    req_opr[r*4 +: 4] = op;
    req_a[r*64 +: 64] = a;
    req_b[r*64 +: 64] = b;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((m_busy || req_valid != 2'b00) && n < budget) begin
      tick();
      n++;
    end
    if (m_busy || req_valid != 2'b00) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_idle actual=busy required=idle within %0d cycles", tag, budget);
    end
  endtask

  task automatic check_rsp(input string name, input int idx, input logic g, input logic err, input logic [63:0] data);
    logic [65:0] act;
    act = (idx < rsp_log.size()) ? rsp_log[idx] : '1;
    checkOutput(name, act, {g, err, data});
  endtask

  initial begin
    int base;
    reset = 1'b0; req_valid = 2'b00; rsp_ready = 2'b11;
    req_opr = '0; req_a = '0; req_b = '0;
    repeat (3) tick();
    reset = 1'b1;

    alu_lat = 2;
    base = rsp_log.size();
    applyStimulus(0, OP_ADD, {32'd1, 32'd2}, {32'd3, 32'd4});
    wait_idle("single", 40);
    check_rsp("single_rsp", base, 1'b0, 1'b0, 64'h00000004_00000006);
    checkOutput("single_latency", last_lat, 6);

    reset = 1'b0;
    tick();
    reset = 1'b1;
    alu_lat = 3;
    base = rsp_log.size();
    applyStimulus(0, OP_SUB, {32'd10, 32'd20}, {32'd3, 32'd5});
    applyStimulus(1, OP_ADD, {32'd7, 32'd8}, {32'd1, 32'd1});
    wait_idle("tie1", 60);
    applyStimulus(0, OP_A, {32'h11, 32'h22}, {32'h0, 32'h0});
    applyStimulus(1, OP_B, {32'h0, 32'h0}, {32'h33, 32'h44});
    wait_idle("tie2", 60);
    check_rsp("tie_rsp0", base, 1'b0, 1'b0, 64'h00000007_0000000F);
    check_rsp("tie_rsp1", base + 1, 1'b1, 1'b0, 64'h00000008_00000009);
    check_rsp("tie_rsp2", base + 2, 1'b0, 1'b0, 64'h00000011_00000022);
    check_rsp("tie_rsp3", base + 3, 1'b1, 1'b0, 64'h00000033_00000044);

    alu_lat = 1000;
    base = rsp_log.size();
    applyStimulus(1, OP_ADD, {32'd1, 32'd1}, {32'd2, 32'd2});
    wait_idle("timeout", 60);
    check_rsp("timeout_rsp", base, 1'b1, 1'b1, 64'd0);
    checkOutput("timeout_start_cycles", last_start_cnt, 16);
    checkOutput("timeout_latency", last_lat, 18);

    alu_lat = TO - 1;
    base = rsp_log.size();
    applyStimulus(0, OP_ADD, {32'hFFFF_FFFF, 32'd1}, {32'd1, 32'd1});
    wait_idle("late_done", 60);
    check_rsp("late_done_rsp", base, 1'b0, 1'b0, 64'h00000000_00000002);
    checkOutput("late_done_latency", last_lat, 19);

    alu_lat = 2;
    base = rsp_log.size();
    rsp_ready = 2'b01;
    applyStimulus(1, OP_ADD, {32'd5, 32'd5}, {32'd1, 32'd2});
    repeat (7) tick();
    applyStimulus(0, OP_SUB, {32'd9, 32'd9}, {32'd2, 32'd3});
    repeat (10) tick();
    checkOutput("bp_held_valid", rsp_valid, 2'b10);
    rsp_ready = 2'b11;
    wait_idle("backpressure", 60);
    check_rsp("bp_rsp1", base, 1'b1, 1'b0, 64'h00000006_00000007);
    check_rsp("bp_rsp0", base + 1, 1'b0, 1'b0, 64'h00000007_00000006);

    alu_lat = 5;
    applyStimulus(0, OP_ADD, {32'd1, 32'd1}, {32'd2, 32'd2});
    repeat (3) tick();
    checkOutput("pre_reset_start", alu_start, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_alu_start", alu_start, 1'b0);
    checkOutput("async_rsp_valid", rsp_valid, 2'b00);
    repeat (2) tick();
    reset = 1'b1;
    alu_lat = 2;
    base = rsp_log.size();
    applyStimulus(1, OP_SUB, {32'd9, 32'd9}, {32'd4, 32'd1});
    wait_idle("post_reset", 40);
    check_rsp("post_reset_rsp", base, 1'b1, 1'b0, 64'h00000005_00000008);
    checkOutput("post_reset_count", rsp_log.size(), base + 1);

`ifdef ALUX_ARB_STATS_EN
    alu_lat = 1;
    repeat (2) begin
      applyStimulus(0, OP_ADD, {32'd1, 32'd0}, {32'd1, 32'd0});
      wait_idle("stats_op", 40);
    end
    alu_lat = 1000;
    applyStimulus(0, OP_ADD, {32'd1, 32'd0}, {32'd1, 32'd0});
    wait_idle("stats_tmo", 60);
    checkOutput("stat_ops0", stat_ops[15:0], m_ops0);
    checkOutput("stat_ops1", stat_ops[31:16], m_ops1);
    checkOutput("stat_tmo", stat_tmo, m_tmo);
    checkOutput("stat_ops0_literal", stat_ops[15:0], 16'd2);
    checkOutput("stat_tmo_literal", stat_tmo, 8'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
